// File: rtl/scr1_dmem_sram.sv
// Data-memory to single-port SRAM bridge with fixed one-cycle response latency.
// Optional build macro: SCR1_DMEM_SRAM_MISALIGN_CHK_EN
//   defined   -> misaligned HWORD/WORD accesses are answered with RDY_ER, no SRAM access
//   undefined -> misaligned HWORD/WORD accesses are silently forced to natural alignment
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | no response pending, dmem_resp = NOTRDY
// ST_RESP   | response for last accepted request due now

package scr1_dmem_sram_pkg;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_sram
    import scr1_dmem_sram_pkg::*;
#(
    parameter int SCR1_SRAM_AWIDTH = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          dmem_req_ack,
    input  logic                          dmem_req,
    input  type_scr1_mem_cmd_e            dmem_cmd,
    input  type_scr1_mem_width_e          dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
    output type_scr1_mem_resp_e           dmem_resp,
    input  logic                          sram_gnt,
    output logic                          sram_ce,
    output logic                          sram_we,
    output logic [3:0]                    sram_be,
    output logic [SCR1_SRAM_AWIDTH-1:0]   sram_addr,
    output logic [31:0]                   sram_wdata,
    input  logic [31:0]                   sram_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic                 err_q, err_d;
    logic                 wr_q, wr_d;
    type_scr1_mem_width_e width_q, width_d;
    logic [1:0]           off_q, off_d;

    logic                 req_err;
    logic                 misalign;
    logic                 accept;
    logic [1:0]           req_off;
    logic [31:0]          rd_shift;

    // Upper address bits beyond the SRAM window are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^dmem_addr[SCR1_DMEM_AWIDTH-1:SCR1_SRAM_AWIDTH+2];

    // Request decode: error classification, byte lanes, lane placement, handshake.
    always_comb begin
        misalign   = 1'b0;
`ifdef SCR1_DMEM_SRAM_MISALIGN_CHK_EN
        misalign   = ((dmem_width == SCR1_MEM_WIDTH_HWORD) && dmem_addr[0])
                   || ((dmem_width == SCR1_MEM_WIDTH_WORD) && (dmem_addr[1:0] != 2'b00));
`endif
        req_err    = ((dmem_cmd != SCR1_MEM_CMD_RD) && (dmem_cmd != SCR1_MEM_CMD_WR))
                   || (dmem_width == SCR1_MEM_WIDTH_ERROR) || misalign;

        sram_be    = 4'b0000;
        req_off    = 2'b00;
        sram_wdata = dmem_wdata;
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                sram_be    = 4'b0001 << dmem_addr[1:0];
                req_off    = dmem_addr[1:0];
                sram_wdata = {4{dmem_wdata[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                // addr[0] is dropped here, which is what forces alignment when unchecked
                sram_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                req_off    = {dmem_addr[1], 1'b0};
                sram_wdata = {2{dmem_wdata[15:0]}};
            end
            SCR1_MEM_WIDTH_WORD: begin
                sram_be    = 4'b1111;
                req_off    = 2'b00;
                sram_wdata = dmem_wdata;
            end
            default: ;
        endcase

        sram_addr    = dmem_addr[SCR1_SRAM_AWIDTH+1:2];
        dmem_req_ack = ~rst & (sram_gnt | req_err);
        accept       = dmem_req & dmem_req_ack;
        sram_ce      = accept & ~req_err;
        sram_we      = sram_ce & (dmem_cmd == SCR1_MEM_CMD_WR);
    end

    // Next-state and response-context capture; context only changes on accept.
    always_comb begin
        state_d = accept ? ST_RESP : ST_IDLE;
        err_d   = err_q;
        wr_d    = wr_q;
        width_d = width_q;
        off_d   = off_q;
        if (accept) begin
            err_d   = req_err;
            wr_d    = (dmem_cmd == SCR1_MEM_CMD_WR);
            width_d = dmem_width;
            off_d   = req_off;
        end
    end

    // State and context registers, synchronous reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            width_q <= SCR1_MEM_WIDTH_BYTE;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            width_q <= width_d;
            off_q   <= off_d;
        end
    end

    // Response formatting; gated by rst so a pending response never leaks during reset.
    always_comb begin
        dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata = '0;
        rd_shift   = sram_rdata >> {off_q, 3'b000};
        if (!rst && (state_q == ST_RESP)) begin
            if (err_q) begin
                dmem_resp = SCR1_MEM_RESP_RDY_ER;
            end else begin
                dmem_resp = SCR1_MEM_RESP_RDY_OK;
                if (!wr_q) begin
                    case (width_q)
                        SCR1_MEM_WIDTH_BYTE:  dmem_rdata = {24'h0, rd_shift[7:0]};
                        SCR1_MEM_WIDTH_HWORD: dmem_rdata = {16'h0, rd_shift[15:0]};
                        default:              dmem_rdata = rd_shift;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_scr1_dmem_sram.sv
// Directed bench for scr1_dmem_sram with a behavioural SRAM and a response scoreboard.
// Honours SCR1_DMEM_SRAM_MISALIGN_CHK_EN for the misaligned-access expectations.
module tb_scr1_dmem_sram;
    import scr1_dmem_sram_pkg::*;

    localparam int AW = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 dmem_req_ack;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr;
    logic [31:0]          dmem_wdata;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
    logic                 sram_gnt;
    logic                 sram_ce;
    logic                 sram_we;
    logic [3:0]           sram_be;
    logic [AW-1:0]        sram_addr;
    logic [31:0]          sram_wdata;
    logic [31:0]          sram_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];

    scr1_dmem_sram #(.SCR1_SRAM_AWIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_req_ack (dmem_req_ack),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .sram_gnt     (sram_gnt),
        .sram_ce      (sram_ce),
        .sram_we      (sram_we),
        .sram_be      (sram_be),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous SRAM: byte-masked write, registered read.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, settle, check pending response and request-side outputs.
    task automatic step(input logic req, input type_scr1_mem_cmd_e cmd,
                        input type_scr1_mem_width_e wid, input logic [31:0] addr,
                        input logic [31:0] wd, input logic gnt,
                        input logic e_ack, input logic e_ce, input logic e_we,
                        input logic [3:0] e_be, input logic [31:0] e_wd, input int e_sa,
                        input type_scr1_mem_resp_e e_rsp, input logic [31:0] e_rd);
        exp_t e;
        rst        = 1'b0;
        dmem_req   = req;
        dmem_cmd   = cmd;
        dmem_width = wid;
        dmem_addr  = addr;
        dmem_wdata = wd;
        sram_gnt   = gnt;
        #1;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{resp: SCR1_MEM_RESP_NOTRDY, rdata: 32'h0};
        chk("resp",  {30'h0, dmem_resp}, {30'h0, e.resp});
        chk("rdata", dmem_rdata, e.rdata);
        chk("ack",   {31'h0, dmem_req_ack}, {31'h0, e_ack});
        chk("ce",    {31'h0, sram_ce}, {31'h0, e_ce});
        chk("we",    {31'h0, sram_we}, {31'h0, e_we});
        if (e_ce) begin
            chk("be",   {28'h0, sram_be}, {28'h0, e_be});
            chk("addr", {{(32-AW){1'b0}}, sram_addr}, e_sa);
        end
        if (e_we) chk("wdata", sram_wdata, e_wd);
        if (req && e_ack) sb.push_back('{resp: e_rsp, rdata: e_rd});
        @(posedge clk);
        #1;
    endtask

    // One clock with reset asserted: everything quiet, pending response discarded.
    task automatic rst_step(input logic req, input logic gnt);
        rst        = 1'b1;
        dmem_req   = req;
        dmem_cmd   = SCR1_MEM_CMD_RD;
        dmem_width = SCR1_MEM_WIDTH_WORD;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        sram_gnt   = gnt;
        #1;
        chk("rst_resp",  {30'h0, dmem_resp}, {30'h0, SCR1_MEM_RESP_NOTRDY});
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_ack",   {31'h0, dmem_req_ack}, 32'h0);
        chk("rst_ce",    {31'h0, sram_ce}, 32'h0);
        chk("rst_we",    {31'h0, sram_we}, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    localparam type_scr1_mem_cmd_e   RD = SCR1_MEM_CMD_RD;
    localparam type_scr1_mem_cmd_e   WR = SCR1_MEM_CMD_WR;
    localparam type_scr1_mem_cmd_e   CE = SCR1_MEM_CMD_ERROR;
    localparam type_scr1_mem_width_e B  = SCR1_MEM_WIDTH_BYTE;
    localparam type_scr1_mem_width_e H  = SCR1_MEM_WIDTH_HWORD;
    localparam type_scr1_mem_width_e W  = SCR1_MEM_WIDTH_WORD;
    localparam type_scr1_mem_width_e WE = SCR1_MEM_WIDTH_ERROR;
    localparam type_scr1_mem_resp_e  OK = SCR1_MEM_RESP_RDY_OK;
    localparam type_scr1_mem_resp_e  ER = SCR1_MEM_RESP_RDY_ER;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        sram_rdata = 32'h0;
        rst_step(1'b0, 1'b1);
        rst_step(1'b1, 1'b1);

        // word write then read back
        step(1, WR, W, 32'h10, 32'hDEADBEEF, 1,  1, 1, 1, 4'b1111, 32'hDEADBEEF, 4, OK, 32'h0);
        step(1, RD, W, 32'h10, 32'h0,        1,  1, 1, 0, 4'b1111, 32'h0,        4, OK, 32'hDEADBEEF);
        // byte read of top lane, halfword write to upper half
        step(1, WR, W, 32'h10, 32'hA1B2C3D4, 1,  1, 1, 1, 4'b1111, 32'hA1B2C3D4, 4, OK, 32'h0);
        step(1, RD, B, 32'h13, 32'h0,        1,  1, 1, 0, 4'b1000, 32'h0,        4, OK, 32'h000000A1);
        step(1, WR, H, 32'h12, 32'h00001234, 1,  1, 1, 1, 4'b1100, 32'h12341234, 4, OK, 32'h0);
        step(1, RD, W, 32'h10, 32'h0,        1,  1, 1, 0, 4'b1111, 32'h0,        4, OK, 32'h1234C3D4);
        step(1, WR, B, 32'h11, 32'h00000055, 1,  1, 1, 1, 4'b0010, 32'h55555555, 4, OK, 32'h0);
        step(1, WR, W, 32'h00, 32'hCAFEF00D, 1,  1, 1, 1, 4'b1111, 32'hCAFEF00D, 0, OK, 32'h0);
        // four back-to-back reads, word 4 now holds 0x123455D4
        step(1, RD, B, 32'h10, 32'h0,        1,  1, 1, 0, 4'b0001, 32'h0,        4, OK, 32'h000000D4);
        step(1, RD, H, 32'h10, 32'h0,        1,  1, 1, 0, 4'b0011, 32'h0,        4, OK, 32'h000055D4);
        step(1, RD, H, 32'h12, 32'h0,        1,  1, 1, 0, 4'b1100, 32'h0,        4, OK, 32'h00001234);
        step(1, RD, B, 32'h12, 32'h0,        1,  1, 1, 0, 4'b0100, 32'h0,        4, OK, 32'h00000034);
        // grant withheld three cycles, the last pending response still completes
        for (int i = 0; i < 3; i++)
            step(1, RD, W, 32'h10, 32'h0,    0,  0, 0, 0, 4'b1111, 32'h0,        4, OK, 32'h0);
        step(1, RD, W, 32'h10, 32'h0,        1,  1, 1, 0, 4'b1111, 32'h0,        4, OK, 32'h123455D4);
        // misaligned accesses
`ifdef SCR1_DMEM_SRAM_MISALIGN_CHK_EN
        step(1, RD, W, 32'h02, 32'h0,        1,  1, 0, 0, 4'b1111, 32'h0,        0, ER, 32'h0);
        step(1, RD, H, 32'h13, 32'h0,        0,  1, 0, 0, 4'b1100, 32'h0,        4, ER, 32'h0);
`else
        step(1, RD, W, 32'h02, 32'h0,        1,  1, 1, 0, 4'b1111, 32'h0,        0, OK, 32'hCAFEF00D);
        step(1, RD, H, 32'h13, 32'h0,        1,  1, 1, 0, 4'b1100, 32'h0,        4, OK, 32'h00001234);
`endif
        step(0, RD, W, 32'h0,  32'h0,        1,  1, 0, 0, 4'b1111, 32'h0,        0, OK, 32'h0);
        // reset in the response cycle drops it; first request right after reset accepted
        step(1, RD, W, 32'h10, 32'h0,        1,  1, 1, 0, 4'b1111, 32'h0,        4, OK, 32'h123455D4);
        rst_step(1'b1, 1'b1);
        step(1, RD, W, 32'h00, 32'h0,        1,  1, 1, 0, 4'b1111, 32'h0,        0, OK, 32'hCAFEF00D);
        // error commands bypass grant and SRAM
        step(1, CE, W, 32'h10, 32'h0,        0,  1, 0, 0, 4'b1111, 32'h0,        4, ER, 32'h0);
        step(1, RD, WE, 32'h10, 32'h0,       1,  1, 0, 0, 4'b0000, 32'h0,        4, ER, 32'h0);
        step(1, WR, W, 32'h10, 32'h0BADF00D, 0,  0, 0, 0, 4'b1111, 32'h0,        4, OK, 32'h0);
        step(0, RD, W, 32'h10, 32'h0,        0,  0, 0, 0, 4'b1111, 32'h0,        4, OK, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
